// File: rtl/vga_regs_pkg.sv
// vga_regs_pkg
//   Shared definitions for the vga_ball frame-update path:
//   - register address map of the vga_ball slave (0..13)
//   - frame_update_t : one frame-update descriptor (boundaries, shift, 3 sprites)
//   - fum_state_t    : frame-update master FSM states
//   - beat_addr/beat_data : map a burst beat index (0..14) to its address and data
package vga_regs_pkg;

  localparam int unsigned NUM_BEATS = 15;

  localparam logic [5:0] REG_B1       = 6'd0;
  localparam logic [5:0] REG_B2       = 6'd1;
  localparam logic [5:0] REG_B3       = 6'd2;
  localparam logic [5:0] REG_B4       = 6'd3;
  localparam logic [5:0] REG_SHIFT    = 6'd4;
  localparam logic [5:0] REG_SPR1_X   = 6'd5;
  localparam logic [5:0] REG_SPR1_ROW = 6'd6;
  localparam logic [5:0] REG_SPR1_IMG = 6'd7;
  localparam logic [5:0] REG_SPR2_X   = 6'd8;
  localparam logic [5:0] REG_SPR2_ROW = 6'd9;
  localparam logic [5:0] REG_SPR2_IMG = 6'd10;
  localparam logic [5:0] REG_SPR3_X   = 6'd11;
  localparam logic [5:0] REG_SPR3_ROW = 6'd12;
  localparam logic [5:0] REG_SPR3_IMG = 6'd13;

  // Field order matches the concatenation of the upd_* ports, MSB first.
  typedef struct packed {
    logic [9:0] b1;
    logic [9:0] b2;
    logic [9:0] b3;
    logic [9:0] b4;
    logic       shift;
    logic [9:0] x1;
    logic [9:0] x2;
    logic [9:0] x3;
    logic [8:0] row1;
    logic [8:0] row2;
    logic [8:0] row3;
    logic       v1;
    logic       v2;
    logic       v3;
    logic [4:0] img1;
    logic [4:0] img2;
    logic [4:0] img3;
  } frame_update_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_VB,
    WRITE,
    DONE
  } fum_state_t;

  // Beats 4 and 5 both target REG_SHIFT so the slave sees a one-write pulse.
  function automatic logic [5:0] beat_addr(input logic [3:0] idx);
    logic [5:0] a;
    case (idx)
      4'd0:    a = REG_B1;
      4'd1:    a = REG_B2;
      4'd2:    a = REG_B3;
      4'd3:    a = REG_B4;
      4'd4:    a = REG_SHIFT;
      4'd5:    a = REG_SHIFT;
      4'd6:    a = REG_SPR1_X;
      4'd7:    a = REG_SPR1_ROW;
      4'd8:    a = REG_SPR1_IMG;
      4'd9:    a = REG_SPR2_X;
      4'd10:   a = REG_SPR2_ROW;
      4'd11:   a = REG_SPR2_IMG;
      4'd12:   a = REG_SPR3_X;
      4'd13:   a = REG_SPR3_ROW;
      4'd14:   a = REG_SPR3_IMG;
      default: a = '0;
    endcase
    return a;
  endfunction

  function automatic logic [15:0] beat_data(input logic [3:0] idx, input frame_update_t fu);
    logic [15:0] d;
    case (idx)
      4'd0:    d = {6'b0, fu.b1};
      4'd1:    d = {6'b0, fu.b2};
      4'd2:    d = {6'b0, fu.b3};
      4'd3:    d = {6'b0, fu.b4};
      4'd4:    d = {15'b0, fu.shift};
      4'd5:    d = '0;
      4'd6:    d = {6'b0, fu.x1};
      4'd7:    d = {6'b0, fu.row1, fu.v1};
      4'd8:    d = {11'b0, fu.img1};
      4'd9:    d = {6'b0, fu.x2};
      4'd10:   d = {6'b0, fu.row2, fu.v2};
      4'd11:   d = {11'b0, fu.img2};
      4'd12:   d = {6'b0, fu.x3};
      4'd13:   d = {6'b0, fu.row3, fu.v3};
      4'd14:   d = {11'b0, fu.img3};
      default: d = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/vga_frame_update_master.sv
// vga_frame_update_master
//   Avalon-MM write initiator for the vga_ball register file. Accepts one
//   frame-update descriptor per valid/ready handshake and replays it as an
//   ordered 15-beat write burst, started on a vblank rising edge so the
//   display never tears mid-frame.
// Ports
//   clk, reset          : clock, synchronous active-high reset
//   upd_valid/upd_ready : descriptor handshake (ready only in IDLE)
//   upd_boundary        : {b1,b2,b3,b4}, 10 bits each
//   upd_shift           : request one scroll step
//   upd_spr_x/row/vis/img : sprite fields, sprite 1 in the MSBs
//   vblank              : vertical blank level
//   avm_*               : Avalon-MM master write port (registered)
//   busy                : high outside IDLE
//   done                : one-cycle pulse after the last beat is accepted
//   late                : one-cycle pulse if vblank ends before the burst finishes
module vga_frame_update_master
  import vga_regs_pkg::*;
#(
  parameter bit WAIT_FOR_VBLANK = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        upd_valid,
  output logic        upd_ready,
  input  logic [39:0] upd_boundary,
  input  logic        upd_shift,
  input  logic [29:0] upd_spr_x,
  input  logic [26:0] upd_spr_row,
  input  logic [2:0]  upd_spr_vis,
  input  logic [14:0] upd_spr_img,
  input  logic        vblank,
  output logic        avm_chipselect,
  output logic        avm_write,
  output logic [5:0]  avm_address,
  output logic [15:0] avm_writedata,
  input  logic        avm_waitrequest,
  output logic        busy,
  output logic        done,
  output logic        late
);

  localparam logic [3:0] LAST_BEAT = 4'(NUM_BEATS - 1);

  fum_state_t    state_q, state_d;
  frame_update_t desc_q, desc_d;
  logic [3:0]    beat_idx_q, beat_idx_d;
  logic          vblank_q, vblank_d;
  logic          late_seen_q, late_seen_d;
  logic          upd_ready_q, upd_ready_d;
  logic          avm_write_q, avm_write_d;
  logic [5:0]    avm_address_q, avm_address_d;
  logic [15:0]   avm_writedata_q, avm_writedata_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          late_q, late_d;

  logic          vb_rise;
  logic          vb_fall;
  logic [3:0]    next_idx;

  assign vb_rise  = vblank & ~vblank_q;
  assign vb_fall  = ~vblank & vblank_q;
  assign next_idx = beat_idx_q + 4'd1;

  always_comb begin
    state_d         = state_q;
    desc_d          = desc_q;
    beat_idx_d      = beat_idx_q;
    vblank_d        = vblank;
    late_seen_d     = late_seen_q;
    upd_ready_d     = upd_ready_q;
    avm_write_d     = avm_write_q;
    avm_address_d   = avm_address_q;
    avm_writedata_d = avm_writedata_q;
    busy_d          = busy_q;
    done_d          = 1'b0;
    late_d          = 1'b0;

    case (state_q)
      IDLE: begin
        if (upd_valid && upd_ready_q) begin
          desc_d      = frame_update_t'({upd_boundary, upd_shift, upd_spr_x,
                                         upd_spr_row, upd_spr_vis, upd_spr_img});
          state_d     = WAIT_VB;
          upd_ready_d = 1'b0;
          busy_d      = 1'b1;
        end
      end

      WAIT_VB: begin
        // Edge detection (not level) means a descriptor accepted inside
        // vblank waits for the next blanking interval.
        if (!WAIT_FOR_VBLANK || vb_rise) begin
          state_d         = WRITE;
          beat_idx_d      = '0;
          late_seen_d     = 1'b0;
          avm_write_d     = 1'b1;
          avm_address_d   = beat_addr(4'd0);
          avm_writedata_d = beat_data(4'd0, desc_q);
        end
      end

      WRITE: begin
        if (vb_fall && !late_seen_q) begin
          late_d      = 1'b1;
          late_seen_d = 1'b1;
        end
        // avm_write_q is always 1 here; the beat completes when not stalled.
        if (!avm_waitrequest) begin
          if (beat_idx_q == LAST_BEAT) begin
            state_d     = DONE;
            avm_write_d = 1'b0;
            done_d      = 1'b1;
          end else begin
            beat_idx_d      = next_idx;
            avm_address_d   = beat_addr(next_idx);
            avm_writedata_d = beat_data(next_idx, desc_q);
          end
        end
      end

      DONE: begin
        state_d     = IDLE;
        upd_ready_d = 1'b1;
        busy_d      = 1'b0;
      end

      default: begin
        state_d     = IDLE;
        avm_write_d = 1'b0;
        upd_ready_d = 1'b1;
        busy_d      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= IDLE;
      desc_q          <= '0;
      beat_idx_q      <= '0;
      vblank_q        <= 1'b0;
      late_seen_q     <= 1'b0;
      upd_ready_q     <= 1'b1;
      avm_write_q     <= 1'b0;
      avm_address_q   <= '0;
      avm_writedata_q <= '0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      late_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      desc_q          <= desc_d;
      beat_idx_q      <= beat_idx_d;
      vblank_q        <= vblank_d;
      late_seen_q     <= late_seen_d;
      upd_ready_q     <= upd_ready_d;
      avm_write_q     <= avm_write_d;
      avm_address_q   <= avm_address_d;
      avm_writedata_q <= avm_writedata_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      late_q          <= late_d;
    end
  end

  assign upd_ready      = upd_ready_q;
  assign avm_write      = avm_write_q;
  assign avm_chipselect = avm_write_q;
  assign avm_address    = avm_address_q;
  assign avm_writedata  = avm_writedata_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign late           = late_q;

endmodule
